// File: rtl/core_sequencer_if.sv
// Instruction-memory handshake and stage-strobe bundle between the sequencer
// (master) and the fetch/decode/execute/retire datapath (slave).
interface core_sequencer_if #(
   parameter int PC_WIDTH = 16
);
   logic                imem_req;
   logic [PC_WIDTH-1:0] imem_addr;
   logic                imem_ack;
   logic [31:0]         imem_rdata;
   logic [31:0]         instr;
   logic                decode_en;
   logic                execute_en;
   logic                retire_en;
   logic                exec_busy;
   logic                branch_taken;
   logic [PC_WIDTH-1:0] branch_target;

   modport master (
      output imem_req, imem_addr, instr, decode_en, execute_en, retire_en,
      input  imem_ack, imem_rdata, exec_busy, branch_taken, branch_target
   );

   modport slave (
      input  imem_req, imem_addr, instr, decode_en, execute_en, retire_en,
      output imem_ack, imem_rdata, exec_busy, branch_taken, branch_target
   );
endinterface

// File: rtl/core_sequencer.sv
// HALT/FETCH/DECODE/EXECUTE/RETIRE controller paced by a divided clock-enable tick.
// Optional fetch-timeout fault enabled by defining CORE_SEQ_FETCH_TIMEOUT_EN.
module core_sequencer #(
   parameter int                  PC_WIDTH      = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC      = {PC_WIDTH{1'b0}},
   parameter int                  TICK_DIV      = 218,
   parameter int                  FETCH_TIMEOUT = 64
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 step,
   core_sequencer_if.master     bus,
   output logic [PC_WIDTH-1:0]  pc,
   output logic [2:0]           state,
   output logic                 halted,
   output logic                 fault
);
   typedef enum logic [2:0] {
      ST_HALT    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_RETIRE  = 3'd4
   } state_t;

   localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   if (TICK_DIV < 1 || FETCH_TIMEOUT < 1) begin : g_bad_param
      $error("core_sequencer: TICK_DIV and FETCH_TIMEOUT must be >= 1");
   end

   state_t              state_r, state_next_s;
   logic [TW-1:0]       tick_cnt_r;
   logic                tick_s;
   logic [PC_WIDTH-1:0] pc_r, pc_next_s;
   logic [31:0]         instr_r;
   logic                halted_r;
   logic                step_pending_r;
   logic                load_instr_s;
   logic                decode_en_s, execute_en_s, retire_en_s;
   logic                fault_s;
   logic                fault_set_s;

   assign tick_s = (tick_cnt_r == TICK_LAST);

   // Free-running tick divider, independent of sequencer state.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         tick_cnt_r <= {TW{1'b0}};
      end else if (tick_s) begin
         tick_cnt_r <= {TW{1'b0}};
      end else begin
         tick_cnt_r <= tick_cnt_r + TW'(1);
      end
   end

`ifdef CORE_SEQ_FETCH_TIMEOUT_EN
   localparam int             TOW     = $clog2(FETCH_TIMEOUT + 1);
   localparam logic [TOW-1:0] TO_LAST = TOW'(FETCH_TIMEOUT - 1);
   logic [TOW-1:0] to_cnt_r;
   logic           fault_r;

   // Counts ack-less FETCH cycles; fault stays set until reset.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         to_cnt_r <= {TOW{1'b0}};
         fault_r  <= 1'b0;
      end else begin
         if (state_r != ST_FETCH || bus.imem_ack) begin
            to_cnt_r <= {TOW{1'b0}};
         end else begin
            to_cnt_r <= to_cnt_r + TOW'(1);
         end
         fault_r <= fault_r | fault_set_s;
      end
   end
   assign fault_s = fault_r;
`else
   assign fault_s = 1'b0;
`endif

   // Next-state, stage strobes and pc update.
   always_comb begin
      state_next_s = state_r;
      pc_next_s    = pc_r;
      load_instr_s = 1'b0;
      decode_en_s  = 1'b0;
      execute_en_s = 1'b0;
      retire_en_s  = 1'b0;
      fault_set_s  = 1'b0;
      case (state_r)
         ST_HALT: begin
            if (tick_s && !fault_s && (run || step_pending_r)) begin
               state_next_s = ST_FETCH;
            end else begin
               state_next_s = ST_HALT;
            end
         end
         ST_FETCH: begin
            if (bus.imem_ack) begin
               load_instr_s = 1'b1;
               state_next_s = ST_DECODE;
`ifdef CORE_SEQ_FETCH_TIMEOUT_EN
            end else if (to_cnt_r == TO_LAST) begin
               fault_set_s  = 1'b1;
               state_next_s = ST_HALT;
`endif
            end else begin
               state_next_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (tick_s) begin
               decode_en_s  = 1'b1;
               state_next_s = ST_EXECUTE;
            end else begin
               state_next_s = ST_DECODE;
            end
         end
         ST_EXECUTE: begin
            if (tick_s) begin
               execute_en_s = 1'b1;
               state_next_s = bus.exec_busy ? ST_EXECUTE : ST_RETIRE;
            end else begin
               state_next_s = ST_EXECUTE;
            end
         end
         ST_RETIRE: begin
            if (tick_s) begin
               retire_en_s  = 1'b1;
               pc_next_s    = bus.branch_taken ? bus.branch_target : pc_r + PC_WIDTH'(1);
               state_next_s = run ? ST_FETCH : ST_HALT;
            end else begin
               state_next_s = ST_RETIRE;
            end
         end
         default: begin
            state_next_s = ST_HALT;
         end
      endcase
   end

   // Sequencer registers; a step only arms while halted and is consumed on leaving HALT.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_r        <= ST_HALT;
         pc_r           <= RESET_PC;
         instr_r        <= 32'h0000_0000;
         halted_r       <= 1'b1;
         step_pending_r <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         pc_r     <= pc_next_s;
         halted_r <= (state_next_s == ST_HALT);
         if (load_instr_s) begin
            instr_r <= bus.imem_rdata;
         end else begin
            instr_r <= instr_r;
         end
         if (state_r == ST_HALT && state_next_s == ST_HALT) begin
            step_pending_r <= step_pending_r | step;
         end else begin
            step_pending_r <= 1'b0;
         end
      end
   end

   // Strobes are suppressed in a reset cycle so no stage fires while state is discarded.
   assign bus.decode_en  = decode_en_s  & ~reset;
   assign bus.execute_en = execute_en_s & ~reset;
   assign bus.retire_en  = retire_en_s  & ~reset;
   assign bus.imem_req   = (state_r == ST_FETCH);
   assign bus.imem_addr  = pc_r;
   assign bus.instr      = instr_r;
   assign pc             = pc_r;
   assign state          = state_r;
   assign halted         = halted_r;
   assign fault          = fault_s;
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: one DUT at TICK_DIV=1 (RESET_PC=0x0010), one at TICK_DIV=4.
module tb_core_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic        ack_en1 = 1'b1;
   logic        busy1 = 1'b0;
   logic        br_taken1 = 1'b0;
   logic [15:0] br_target1 = 16'h0000;
   int          errors = 0;
   int          checks = 0;

   logic [15:0] pc1, pc4;
   logic [2:0]  state1, state4;
   logic        halted1, halted4, fault1, fault4;

   core_sequencer_if #(.PC_WIDTH(16)) if1 ();
   core_sequencer_if #(.PC_WIDTH(16)) if4 ();

   assign if1.imem_ack      = ack_en1 & if1.imem_req;
   assign if1.imem_rdata    = {16'hC0DE, if1.imem_addr};
   assign if1.exec_busy     = busy1;
   assign if1.branch_taken  = br_taken1;
   assign if1.branch_target = br_target1;
   assign if4.imem_ack      = if4.imem_req;
   assign if4.imem_rdata    = {16'hBEEF, if4.imem_addr};
   assign if4.exec_busy     = 1'b0;
   assign if4.branch_taken  = 1'b0;
   assign if4.branch_target = 16'h0000;

   core_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0010), .TICK_DIV(1), .FETCH_TIMEOUT(8)) u_dut1 (
      .CLOCK_50(clk), .reset(reset), .run(run), .step(step), .bus(if1.master),
      .pc(pc1), .state(state1), .halted(halted1), .fault(fault1)
   );

   core_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000), .TICK_DIV(4), .FETCH_TIMEOUT(8)) u_dut4 (
      .CLOCK_50(clk), .reset(reset), .run(run), .step(step), .bus(if4.master),
      .pc(pc4), .state(state4), .halted(halted4), .fault(fault4)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset(input logic run_after);
      reset = 1'b1; run = 1'b0; step = 1'b0; ack_en1 = 1'b1;
      busy1 = 1'b0; br_taken1 = 1'b0; br_target1 = 16'h0000;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      run   = run_after;
   endtask

   task automatic test_reset();
      reset = 1'b1; run = 1'b0; step = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (state1 !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state1); end
      checks++; if (halted1 !== 1'b1) begin errors++; $display("FAIL reset_halted got %b exp 1", halted1); end
      checks++; if (pc1 !== 16'h0010) begin errors++; $display("FAIL reset_pc1 got %h exp 0010", pc1); end
      checks++; if (pc4 !== 16'h0000) begin errors++; $display("FAIL reset_pc4 got %h exp 0000", pc4); end
      checks++; if (if1.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", if1.imem_req); end
      checks++; if (if1.instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", if1.instr); end
      checks++; if ({if1.decode_en, if1.execute_en, if1.retire_en} !== 3'b000) begin
         errors++; $display("FAIL reset_strobes got %b exp 000", {if1.decode_en, if1.execute_en, if1.retire_en}); end
      checks++; if (fault1 !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault1); end
   endtask

   task automatic test_run_tick();
      logic [2:0]  exp_st1, exp_st4, exp_sb1, exp_sb4;
      logic [15:0] exp_addr;
      apply_reset(1'b1);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         exp_st1 = 3'(((k - 1) % 4) + 1);
         exp_sb1 = {(k % 4 == 2), (k % 4 == 3), (k % 4 == 0)};
         exp_st4 = (k < 4) ? 3'd0 : (k == 4 || k == 16) ? 3'd1 : (k < 8) ? 3'd2 : (k < 12) ? 3'd3 : 3'd4;
         exp_sb4 = {(k == 7), (k == 11), (k == 15)};
         checks++; if (state1 !== exp_st1) begin errors++; $display("FAIL run1_state c%0d got %0d exp %0d", k, state1, exp_st1); end
         checks++; if ({if1.decode_en, if1.execute_en, if1.retire_en} !== exp_sb1) begin
            errors++; $display("FAIL run1_strobes c%0d got %b exp %b", k, {if1.decode_en, if1.execute_en, if1.retire_en}, exp_sb1); end
         checks++; if (state4 !== exp_st4) begin errors++; $display("FAIL run4_state c%0d got %0d exp %0d", k, state4, exp_st4); end
         checks++; if ({if4.decode_en, if4.execute_en, if4.retire_en} !== exp_sb4) begin
            errors++; $display("FAIL run4_strobes c%0d got %b exp %b", k, {if4.decode_en, if4.execute_en, if4.retire_en}, exp_sb4); end
         checks++; if (halted4 !== (k < 4)) begin errors++; $display("FAIL run4_halted c%0d got %b exp %b", k, halted4, (k < 4)); end
         if (k % 4 == 1) begin
            exp_addr = 16'h0010 + 16'((k - 1) / 4);
            checks++; if (if1.imem_req !== 1'b1 || if1.imem_addr !== exp_addr) begin
               errors++; $display("FAIL run1_fetch c%0d got req=%b addr=%h exp req=1 addr=%h", k, if1.imem_req, if1.imem_addr, exp_addr); end
         end
         if (k == 2) begin
            checks++; if (if1.instr !== 32'hC0DE0010) begin errors++; $display("FAIL run1_instr got %h exp C0DE0010", if1.instr); end
         end
      end
      run = 1'b0;
   endtask

   task automatic test_step();
      int retires;
      logic [15:0] exp_pc;
      apply_reset(1'b0);
      repeat (3) @(negedge clk);
      checks++; if (halted1 !== 1'b1 || pc1 !== 16'h0010) begin
         errors++; $display("FAIL step_idle got halted=%b pc=%h exp halted=1 pc=0010", halted1, pc1); end
      for (int s = 1; s <= 2; s++) begin
         exp_pc = 16'h0010 + 16'(s);
         step = 1'b1;
         @(negedge clk);
         step = 1'b0;
         retires = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if1.retire_en) retires++;
         end
         checks++; if (retires !== 1) begin errors++; $display("FAIL step%0d_retires got %0d exp 1", s, retires); end
         checks++; if (halted1 !== 1'b1) begin errors++; $display("FAIL step%0d_halted got %b exp 1", s, halted1); end
         checks++; if (pc1 !== exp_pc) begin errors++; $display("FAIL step%0d_pc got %h exp %h", s, pc1, exp_pc); end
      end
   endtask

   task automatic test_busy_branch();
      int  exe_cnt = 0;
      int  ret_cnt = 0;
      int  exe_at_ret = 0;
      logic seen_fetch2 = 1'b0;
      apply_reset(1'b1);
      busy1 = 1'b1; br_taken1 = 1'b1; br_target1 = 16'hFFFF;
      for (int i = 0; i < 40 && ret_cnt < 2; i++) begin
         @(negedge clk);
         if (if1.execute_en) exe_cnt++;
         if (if1.retire_en) begin
            ret_cnt++;
            if (ret_cnt == 1) exe_at_ret = exe_cnt;
         end
         busy1 = (exe_cnt < 3);
         if (state1 == 3'd1 && ret_cnt == 1 && !seen_fetch2) begin
            seen_fetch2 = 1'b1;
            br_taken1 = 1'b0;
            checks++; if (pc1 !== 16'hFFFF || if1.imem_addr !== 16'hFFFF) begin
               errors++; $display("FAIL branch_pc got pc=%h addr=%h exp FFFF", pc1, if1.imem_addr); end
         end
      end
      checks++; if (ret_cnt !== 2) begin errors++; $display("FAIL busy_retires got %0d exp 2", ret_cnt); end
      checks++; if (exe_at_ret !== 3) begin errors++; $display("FAIL busy_exec_pulses got %0d exp 3", exe_at_ret); end
      checks++; if (exe_cnt !== 4) begin errors++; $display("FAIL busy_exec_total got %0d exp 4", exe_cnt); end
      @(negedge clk);
      checks++; if (pc1 !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %h exp 0000", pc1); end
      run = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n;
      apply_reset(1'b1);
      n = 0;
      while (state1 !== 3'd2 && n < 20) begin @(negedge clk); n++; end
      reset = 1'b1; run = 1'b0;
      #1;
      checks++; if ({if1.decode_en, if1.execute_en, if1.retire_en} !== 3'b000) begin
         errors++; $display("FAIL reset_cycle_strobe got %b exp 000", {if1.decode_en, if1.execute_en, if1.retire_en}); end
      @(negedge clk);
      checks++; if (state1 !== 3'd0) begin errors++; $display("FAIL reset_decode_state got %0d exp 0", state1); end
      reset = 1'b0; run = 1'b1;
      n = 0;
      while (if1.retire_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      ack_en1 = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (state1 !== 3'd1 || if1.imem_req !== 1'b1 || if1.imem_addr !== 16'h0011) begin
         errors++; $display("FAIL stall_fetch got st=%0d req=%b addr=%h exp st=1 req=1 addr=0011", state1, if1.imem_req, if1.imem_addr); end
      reset = 1'b1; run = 1'b0;
      @(negedge clk);
      checks++; if (state1 !== 3'd0 || if1.imem_req !== 1'b0 || pc1 !== 16'h0010 || halted1 !== 1'b1) begin
         errors++; $display("FAIL reset_fetch got st=%0d req=%b pc=%h halted=%b exp st=0 req=0 pc=0010 halted=1",
                            state1, if1.imem_req, pc1, halted1); end
      ack_en1 = 1'b1;
   endtask

`ifdef CORE_SEQ_FETCH_TIMEOUT_EN
   task automatic test_timeout();
      int fc = 0;
      apply_reset(1'b1);
      ack_en1 = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (state1 == 3'd1) fc++;
      end
      checks++; if (fc !== 8) begin errors++; $display("FAIL timeout_cycles got %0d exp 8", fc); end
      checks++; if (fault1 !== 1'b1 || state1 !== 3'd0 || pc1 !== 16'h0010) begin
         errors++; $display("FAIL timeout_fault got fault=%b st=%0d pc=%h exp 1 0 0010", fault1, state1, pc1); end
      step = 1'b1; @(negedge clk); step = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (state1 !== 3'd0 || fault1 !== 1'b1) begin
         errors++; $display("FAIL timeout_sticky got st=%0d fault=%b exp 0 1", state1, fault1); end
      apply_reset(1'b0);
      @(negedge clk);
      checks++; if (fault1 !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b exp 0", fault1); end
   endtask
`endif

   initial begin
      test_reset();
      test_run_tick();
      test_step();
      test_busy_branch();
      test_reset_mid();
`ifdef CORE_SEQ_FETCH_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Instruction-cycle controller for the core datapath. Sequences HALT → FETCH → DECODE → EXECUTE → RETIRE using an internal clock-enable tick divided from CLOCK_50 rather than a derived clock. Owns the program counter, drives the instruction-memory request handshake and issues one-cycle stage enables to the decode, execute and retire logic. Supports run/halt, single-step and multi-cycle execute stalls.

## Interface
- PC_WIDTH, 16, program counter and instruction address width
- RESET_PC, 0, PC value loaded on reset
- TICK_DIV, 218, CLOCK_50 cycles per tick; ≥1; 1 = tick every cycle
- FETCH_TIMEOUT, 64, FETCH cycles without ack before fault (used only with macro)

- CLOCK_50  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- run  in  1  level; 1 = free-run, 0 = halt at next instruction boundary
- step  in  1  one-cycle pulse; while halted, run exactly one instruction
- imem_req  out  1  fetch request
- imem_addr  out  PC_WIDTH  fetch address (= pc)
- imem_ack  in  1  fetch data valid
- imem_rdata  in  32  fetched instruction word
- instr  out  32  latched instruction
- decode_en / execute_en / retire_en  out  1 each  one-cycle stage strobes
- exec_busy  in  1  execute needs another tick
- branch_taken  in  1, branch_target  in  PC_WIDTH  sampled on retire_en cycle
- pc  out  PC_WIDTH  current program counter
- state  out  3  HALT=0, FETCH=1, DECODE=2, EXECUTE=3, RETIRE=4
- halted  out  1  state == HALT
- fault  out  1  sticky fetch-timeout flag

## Operation
- Reset values: state=HALT, pc=RESET_PC, instr=0, strobes=0, imem_req=0, halted=1, fault=0, tick counter=0, step_pending=0.
- Tick: counter 0..TICK_DIV-1, free-running, independent of state; tick=1 in the cycle count==TICK_DIV-1, then counter wraps to 0.
- step_pending: set on step=1 in HALT; cleared when HALT is left. step outside HALT is ignored.
- HALT: on tick, if fault=0 and (run or step_pending) → FETCH.
- FETCH: imem_req = (state==FETCH), decoded from the registered state. imem_addr=pc, held stable. On first cycle with imem_ack=1: instr←imem_rdata, → DECODE. Not tick-gated. ack outside FETCH is ignored.
- DECODE: on tick, decode_en=1 for that cycle → EXECUTE.
- EXECUTE: on tick, execute_en=1. If exec_busy=1 in that cycle, stay and strobe again next tick; otherwise → RETIRE.
- RETIRE: on tick, retire_en=1; pc←branch_taken ? branch_target : pc+1, modulo 2^PC_WIDTH (wraps to 0). Next state FETCH if run=1, else HALT.
- Strobes are combinational from (state, tick) and never overlap.

## Timing
- With TICK_DIV=1 and same-cycle ack, one instruction takes 4 cycles: FETCH, DECODE, EXECUTE, RETIRE.
- Reset deassert at cycle 0, run=1, TICK_DIV=1: FETCH at cycle 1, decode_en at 2, execute_en at 3, retire_en at 4, next FETCH at 5.
- With TICK_DIV=N, each tick-gated stage waits for the next tick. The first tick after reset occurs at cycle N-1.
- Ack may arrive in the first imem_req cycle. imem_req drops the cycle after ack.
- Reset mid-operation: all state returns to reset values next edge. An in-flight fetch is abandoned (imem_req low next cycle). No strobe is issued in the reset cycle.
- run falling mid-instruction: the instruction completes through RETIRE, then HALT.

## Configuration
- Macro CORE_SEQ_FETCH_TIMEOUT_EN.
- Defined: counter clears on FETCH entry and increments each FETCH cycle without ack. At FETCH_TIMEOUT cycles: fault←1, → HALT, pc unchanged. fault is sticky until reset and blocks run/step.
- Undefined: FETCH waits indefinitely; fault tied 0; no counter logic.

## Test plan
- TICK_DIV=1, RESET_PC=0x0010, run=1, ack same cycle, branch_taken=0 → retire_en at cycles 4, 8, 12; imem_addr 0x0010, 0x0011, 0x0012.
- TICK_DIV=4, run=1 → FETCH at cycle 4; decode_en/execute_en/retire_en only on tick cycles 4k+3.
- run=0, step pulse in HALT → exactly one retire_en, then halted=1; a second step → pc advances by exactly 1 again.
- exec_busy=1 for 2 ticks, branch_taken=1 with target 0xFFFF at retire → execute_en pulses 3 times, pc=0xFFFF; next sequential retire wraps pc to 0x0000.
- Reset asserted during FETCH with ack withheld → next cycle state=HALT, imem_req=0, pc=RESET_PC.
- Macro defined, FETCH_TIMEOUT=8, no ack → fault=1 and state=HALT after 8 FETCH cycles; run=1 and step are ignored until reset.
